// File: rtl/mpcache_pkg.sv
// Shared multi-port cache definitions: SRAM geometry, read-path FSM states, return-buffer word.
package mpcache_pkg;
  localparam int BLK_ADDR_WIDTH = 12;
  localparam int DATA_WIDTH     = 64;
  localparam int SRAM_RD_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } rd_word_t;
endpackage

// File: rtl/read_sram_buf.sv
// Return buffer: synchronous FIFO, data valid at head the cycle after push.
// No full flag: the caller's credit scheme bounds occupancy to DEPTH.
module read_sram_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
endmodule

// File: rtl/read_sram.sv
// Block read engine: accept->ren 1 cycle, ren->o_data_vld RD_LAT+1 cycles, 1 word/cycle sustained.
// Downstream stalls hold the head word; issue pauses once BUF_DEPTH reads are outstanding.
module read_sram #(
  parameter int BLK_ADDR_WIDTH = mpcache_pkg::BLK_ADDR_WIDTH,
  parameter int DATA_WIDTH     = mpcache_pkg::DATA_WIDTH,
  parameter int RD_LAT         = mpcache_pkg::SRAM_RD_LAT,
  parameter int BUF_DEPTH      = 8,
  parameter int LEN_WIDTH      = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [BLK_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LEN_WIDTH-1:0]      i_req_len,
  input  logic                      i_req_vld,
  output logic                      o_req_rdy,
  output logic [BLK_ADDR_WIDTH-1:0] o_sram_addr,
  output logic                      o_sram_ren,
  input  logic [DATA_WIDTH-1:0]     i_sram_data,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_data_vld,
  output logic                      o_data_last,
  input  logic                      i_data_rdy,
  output logic                      o_busy
);
  import mpcache_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH + 1);

  rd_state_t                 r_state;
  rd_state_t                 w_state_nxt;
  logic [BLK_ADDR_WIDTH-1:0] r_cur_addr;
  logic [BLK_ADDR_WIDTH-1:0] r_sram_addr;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic                      r_sram_ren;
  logic                      r_ren_last;
  logic [RD_LAT-1:0]         r_vld_pipe;
  logic [RD_LAT-1:0]         r_last_pipe;
  logic [CW-1:0]             r_credit;

  logic                      w_accept;
  logic                      w_issue;
  logic                      w_pop;
  logic                      w_empty;
  logic [BLK_ADDR_WIDTH-1:0] w_addr;
  logic [LEN_WIDTH-1:0]      w_rem;
  rd_word_t                  w_push_word;
  rd_word_t                  w_head;

  assign o_req_rdy = (r_state == IDLE) && !i_rst;
  assign w_accept  = i_req_vld && o_req_rdy;
  // The accepting cycle issues the first read itself so ren appears one cycle after accept.
  assign w_addr    = w_accept ? i_req_addr : r_cur_addr;
  assign w_rem     = w_accept ? i_req_len  : r_remaining;
  assign w_issue   = w_accept || ((r_state == ISSUE) && (r_credit < CW'(BUF_DEPTH)));
  assign w_pop     = !w_empty && i_data_rdy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_rem == '0) ? DRAIN : ISSUE;
      ISSUE:   if (w_issue && (w_rem == '0)) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && w_head.last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_sram_addr <= '0;
      r_remaining <= '0;
      r_sram_ren  <= 1'b0;
      r_ren_last  <= 1'b0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_credit    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sram_ren <= w_issue;
      r_ren_last <= w_issue && (w_rem == '0);
      if (w_issue) begin
        r_sram_addr <= w_addr;
        r_cur_addr  <= w_addr + BLK_ADDR_WIDTH'(1);
        r_remaining <= w_rem - LEN_WIDTH'(1);
      end
      r_vld_pipe[0]  <= r_sram_ren;
      r_last_pipe[0] <= r_ren_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit + CW'(1);
        2'b01:   r_credit <= r_credit - CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_comb begin
    w_push_word      = '0;
    w_push_word.last = r_last_pipe[RD_LAT-1];
    w_push_word.data = i_sram_data;
  end

  read_sram_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(rd_word_t))
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_vld_pipe[RD_LAT-1]),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  assign o_sram_ren  = r_sram_ren;
  assign o_sram_addr = r_sram_addr;
  assign o_data_vld  = !w_empty;
  assign o_data      = w_empty ? '0 : w_head.data;
  assign o_data_last = !w_empty && w_head.last;
  assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_read_sram.sv
// Scoreboard bench for read_sram: behavioural SRAM with RD_LAT=2, expected addresses/words queued at request time.
module tb_read_sram;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_req_addr;
  logic [5:0]  i_req_len;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [11:0] o_sram_addr;
  logic        o_sram_ren;
  logic [63:0] i_sram_data;
  logic [63:0] o_data;
  logic        o_data_vld;
  logic        o_data_last;
  logic        i_data_rdy;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_ren = 0;
  int n_pop = 0;
  int outst = 0;
  int max_out = 0;
  int n_vld = 0;

  logic [11:0] exp_addr[$];
  logic [64:0] exp_word[$];

  logic        sram_v1 = 1'b0, sram_v2 = 1'b0;
  logic [11:0] sram_a1 = '0, sram_a2 = '0;
  logic        stall_prev = 1'b0;
  logic [64:0] prev_word = '0;

  always #5 i_clk = ~i_clk;

  read_sram dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_addr  (i_req_addr),
    .i_req_len   (i_req_len),
    .i_req_vld   (i_req_vld),
    .o_req_rdy   (o_req_rdy),
    .o_sram_addr (o_sram_addr),
    .o_sram_ren  (o_sram_ren),
    .i_sram_data (i_sram_data),
    .o_data      (o_data),
    .o_data_vld  (o_data_vld),
    .o_data_last (o_data_last),
    .i_data_rdy  (i_data_rdy),
    .o_busy      (o_busy)
  );

  function automatic logic [63:0] pat(input logic [11:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return {4'hA, ~a, 4'h5, a, h};
  endfunction

  // SRAM model: data for a read is on the bus two cycles after its ren, junk otherwise.
  always @(posedge i_clk) begin
    sram_v1 <= o_sram_ren;
    sram_a1 <= o_sram_addr;
    sram_v2 <= sram_v1;
    sram_a2 <= sram_a1;
  end
  assign i_sram_data = sram_v2 ? pat(sram_a2) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (o_sram_ren) begin
        n_ren++;
        outst++;
        if (exp_addr.size() == 0) check("ren_unexpected", 1, 0);
        else check("ren_addr", 72'(o_sram_addr), 72'(exp_addr.pop_front()));
      end
      if (o_data_vld) n_vld++;
      if (o_data_vld && stall_prev) check("stall_hold", 72'({o_data_last, o_data}), 72'(prev_word));
      if (o_data_vld && i_data_rdy) begin
        n_pop++;
        outst--;
        if (exp_word.size() == 0) check("data_unexpected", 1, 0);
        else check("data_word", 72'({o_data_last, o_data}), 72'(exp_word.pop_front()));
      end
      if (outst > max_out) max_out = outst;
      if (o_sram_ren) check("credit_le_8", 72'(outst <= 8), 1);
      stall_prev = o_data_vld && !i_data_rdy;
      prev_word  = {o_data_last, o_data};
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_req(input logic [11:0] a, input logic [5:0] l);
    check("req_rdy_before_req", 72'(o_req_rdy), 1);
    i_req_addr = a;
    i_req_len  = l;
    i_req_vld  = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      exp_addr.push_back(12'(a + 12'(i)));
      exp_word.push_back({i == int'(l), pat(12'(a + 12'(i)))});
    end
    cyc();
    i_req_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tgl, output int n);
    n = 0;
    while ((o_busy || exp_word.size() != 0) && n < budget) begin
      cyc();
      if (tgl) i_data_rdy = ~i_data_rdy;
      n++;
    end
    check("done_in_budget", 72'(n < budget), 1);
    check("addr_queue_empty", 72'(exp_addr.size()), 0);
    check("req_rdy_after_done", 72'(o_req_rdy), 1);
    i_data_rdy = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ren"},  72'(o_sram_ren), 0);
    check({tag, "_addr"}, 72'(o_sram_addr), 0);
    check({tag, "_vld"},  72'(o_data_vld), 0);
    check({tag, "_data"}, 72'(o_data), 0);
    check({tag, "_last"}, 72'(o_data_last), 0);
    check({tag, "_busy"}, 72'(o_busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, p0, cnt;
    i_rst = 1'b1; i_req_addr = '0; i_req_len = '0; i_req_vld = 1'b0; i_data_rdy = 1'b1;
    repeat (3) cyc();
    check("rst_req_rdy", 72'(o_req_rdy), 0);
    check_outputs_zero("rst");
    i_rst = 1'b0;
    #1;
    check("post_rst_req_rdy", 72'(o_req_rdy), 1);
    cyc();

    // Single word: cycle-exact latency.
    send_req(12'h010, 6'd0);
    check("single_ren_t1", 72'(o_sram_ren), 1);
    check("single_addr_t1", 72'(o_sram_addr), 72'h010);
    check("single_busy_t1", 72'(o_busy), 1);
    cyc();
    check("single_ren_t2", 72'(o_sram_ren), 0);
    check("single_vld_t2", 72'(o_data_vld), 0);
    cyc();
    check("single_vld_t3", 72'(o_data_vld), 0);
    cyc();
    check("single_vld_t4", 72'({o_data_vld, o_data_last}), 72'b11);
    check("single_data_t4", 72'(o_data), 72'(pat(12'h010)));
    check("single_rdy_t4", 72'(o_req_rdy), 0);
    cyc();
    check("single_rdy_t5", 72'(o_req_rdy), 1);
    check("single_busy_t5", 72'(o_busy), 0);
    cyc();

    // Burst of 8 at full rate.
    r0 = n_ren;
    send_req(12'h020, 6'd7);
    wait_done(200, 1'b0, n);
    check("burst_ren_count", 72'(n_ren - r0), 8);
    check("burst_cycles", 72'(n), 11);
    cyc();

    // Backpressure: credits cap issue at 8.
    r0 = n_ren; max_out = 0;
    i_data_rdy = 1'b0;
    send_req(12'h040, 6'd15);
    repeat (20) cyc();
    check("bp_ren_stalled", 72'(n_ren - r0), 8);
    check("bp_outstanding", 72'(outst), 8);
    check("bp_ren_low", 72'(o_sram_ren), 0);
    check("bp_vld_held", 72'(o_data_vld), 1);
    i_data_rdy = 1'b1;
    wait_done(200, 1'b0, n);
    check("bp_ren_total", 72'(n_ren - r0), 16);
    check("bp_max_out", 72'(max_out), 8);
    cyc();

    // Address wrap.
    send_req(12'hFFE, 6'd3);
    wait_done(200, 1'b0, n);
    cyc();

    // Credit boundary with toggling ready.
    p0 = n_pop; max_out = 0;
    send_req(12'h300, 6'd31);
    wait_done(500, 1'b1, n);
    check("credit_pops", 72'(n_pop - p0), 32);
    check("credit_max_le_8", 72'(max_out <= 8), 1);
    cyc();

    // Reset during the third read of a burst.
    send_req(12'h080, 6'd7);
    cnt = 1;
    n = 0;
    while (cnt < 3 && n < 50) begin
      cyc();
      if (o_sram_ren) cnt++;
      n++;
    end
    check("rst_found_third_ren", 72'(cnt), 3);
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    exp_addr.delete();
    exp_word.delete();
    outst = 0;
    #1;
    check_outputs_zero("midrst");
    check("midrst_req_rdy", 72'(o_req_rdy), 1);
    n_vld = 0;
    repeat (8) cyc();
    check("midrst_no_emit", 72'(n_vld), 0);
    send_req(12'h100, 6'd1);
    wait_done(200, 1'b0, n);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
